// File: rtl/up_down_counter_param_if.sv
// Control/status bundle for the parametrised up/down counter.
// The testbench or parent drives through master; the counter uses slave.
interface up_down_counter_param_if #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 2
);
    logic              clear;
    logic              load;
    logic [WIDTH-1:0]  load_val;
    logic              en;
    logic              up_down;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  bin_count;
    logic              ovf;
    logic              unf;
    logic              at_max;
    logic              at_min;

    modport master (
        output clear, load, load_val, en, up_down, step,
        input  bin_count, ovf, unf, at_max, at_min
    );

    modport slave (
        input  clear, load, load_val, en, up_down, step,
        output bin_count, ovf, unf, at_max, at_min
    );
endinterface

// File: rtl/up_down_counter_param.sv
// Parametrised up/down counter: modulus, wrap/saturate, variable step,
// clear/load/enable priority and registered overflow/underflow pulses.
module up_down_counter_param #(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = 2**WIDTH-1,
    parameter int STEP_W   = 2,
    parameter bit SATURATE = 1'b0
) (
    input logic clk,
    input logic rst,
    up_down_counter_param_if.slave bus
);
    // Wide enough for count+step and for an unclipped step input.
    localparam int AW = ((STEP_W > WIDTH) ? STEP_W : WIDTH) + 1;
    localparam logic [AW-1:0] MAXV = AW'(MAX_VAL);
    localparam logic [AW-1:0] MODV = AW'(MAX_VAL + 1);

    logic [WIDTH-1:0] r_count;
    logic             r_ovf;
    logic             r_unf;

    logic [AW-1:0]    w_cnt;
    logic [AW-1:0]    w_step;
    logic [AW-1:0]    w_s;
    logic [AW-1:0]    w_sum;
    logic [AW-1:0]    w_diff;
    logic [AW-1:0]    w_wrap_up;
    logic [AW-1:0]    w_wrap_dn;
    logic [AW-1:0]    w_load;
    logic             w_up_ovf;
    logic             w_dn_unf;

    logic [WIDTH-1:0] w_count_nxt;
    logic             w_ovf_nxt;
    logic             w_unf_nxt;

    assign w_cnt     = AW'(r_count);
    assign w_step    = AW'(bus.step);
    assign w_s       = (w_step > MAXV) ? MAXV : w_step;
    assign w_sum     = w_cnt + w_s;
    assign w_diff    = w_cnt - w_s;
    assign w_wrap_up = w_sum - MODV;
    assign w_wrap_dn = w_cnt + MODV - w_s;
    assign w_up_ovf  = (w_sum > MAXV);
    assign w_dn_unf  = (w_s > w_cnt);
    assign w_load    = AW'(bus.load_val);

    always_comb begin
        w_count_nxt = r_count;
        w_ovf_nxt   = 1'b0;
        w_unf_nxt   = 1'b0;
        if (bus.clear) begin
            w_count_nxt = '0;
        end else if (bus.load) begin
            w_count_nxt = (w_load > MAXV) ? WIDTH'(MAXV)
                                          : bus.load_val;
        end else if (bus.en && (w_s != '0)) begin
            if (bus.up_down) begin
                if (w_up_ovf) begin
                    w_ovf_nxt   = 1'b1;
                    w_count_nxt = SATURATE ? WIDTH'(MAXV)
                                           : WIDTH'(w_wrap_up);
                end else begin
                    w_count_nxt = WIDTH'(w_sum);
                end
            end else begin
                if (w_dn_unf) begin
                    w_unf_nxt   = 1'b1;
                    w_count_nxt = SATURATE ? '0
                                           : WIDTH'(w_wrap_dn);
                end else begin
                    w_count_nxt = WIDTH'(w_diff);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_ovf   <= w_ovf_nxt;
            r_unf   <= w_unf_nxt;
        end
    end

    assign bus.bin_count = r_count;
    assign bus.ovf       = r_ovf;
    assign bus.unf       = r_unf;
    assign bus.at_max    = (w_cnt == MAXV);
    assign bus.at_min    = (r_count == '0);
endmodule

// File: tb/tb_up_down_counter_param.sv
// Directed bench: full-range wrap, decade wrap, decade saturate,
// priority and asynchronous reset, each step with hand-computed values.
module tb_up_down_counter_param;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    up_down_counter_param_if #(.WIDTH(4), .STEP_W(2)) if0 ();
    up_down_counter_param_if #(.WIDTH(4), .STEP_W(2)) if1 ();
    up_down_counter_param_if #(.WIDTH(4), .STEP_W(2)) if2 ();

    up_down_counter_param #(
        .WIDTH(4), .MAX_VAL(15), .STEP_W(2), .SATURATE(1'b0)
    ) d0 (.clk(clk), .rst(rst), .bus(if0));

    up_down_counter_param #(
        .WIDTH(4), .MAX_VAL(9), .STEP_W(2), .SATURATE(1'b0)
    ) d1 (.clk(clk), .rst(rst), .bus(if1));

    up_down_counter_param #(
        .WIDTH(4), .MAX_VAL(9), .STEP_W(2), .SATURATE(1'b1)
    ) d2 (.clk(clk), .rst(rst), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [7:0] obs,
                         input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d",
                   tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        {if0.clear, if0.load, if0.load_val} = '0;
        {if0.en, if0.up_down, if0.step}     = '0;
        {if1.clear, if1.load, if1.load_val} = '0;
        {if1.en, if1.up_down, if1.step}     = '0;
        {if2.clear, if2.load, if2.load_val} = '0;
        {if2.en, if2.up_down, if2.step}     = '0;

        @(negedge clk);
        @(negedge clk);
        check("rst_count", 8'(if0.bin_count), 8'd0);
        check("rst_ovf",   8'(if0.ovf),       8'd0);
        check("rst_unf",   8'(if0.unf),       8'd0);
        check("rst_min",   8'(if0.at_min),    8'd1);
        check("rst_max",   8'(if0.at_max),    8'd0);
        rst = 1'b0;

        // Full-range wrap counting up
        if0.en = 1'b1;
        if0.up_down = 1'b1;
        if0.step = 2'd1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check("up_count", 8'(if0.bin_count), 8'(i % 16));
            check("up_ovf",   8'(if0.ovf),       8'(i == 16));
            check("up_max",   8'(if0.at_max),    8'(i == 15));
        end

        // Down from zero wraps to 15 with underflow
        if0.up_down = 1'b0;
        tick();
        check("dn_wrap",     8'(if0.bin_count), 8'd15);
        check("dn_wrap_unf", 8'(if0.unf),       8'd1);
        check("dn_wrap_ovf", 8'(if0.ovf),       8'd0);
        tick();
        check("dn_14",     8'(if0.bin_count), 8'd14);
        check("dn_14_unf", 8'(if0.unf),       8'd0);

        // Decade wrap
        if1.load = 1'b1;
        if1.load_val = 4'd7;
        tick();
        check("dec_ld7", 8'(if1.bin_count), 8'd7);
        if1.load = 1'b0;
        if1.en = 1'b1;
        if1.up_down = 1'b1;
        if1.step = 2'd3;
        tick();
        check("dec_up",     8'(if1.bin_count), 8'd0);
        check("dec_up_ovf", 8'(if1.ovf),       8'd1);
        if1.en = 1'b0;
        if1.load = 1'b1;
        if1.load_val = 4'd1;
        tick();
        check("dec_ld1",     8'(if1.bin_count), 8'd1);
        check("dec_ld_ovf",  8'(if1.ovf),       8'd0);
        if1.load = 1'b0;
        if1.en = 1'b1;
        if1.up_down = 1'b0;
        tick();
        check("dec_dn",     8'(if1.bin_count), 8'd8);
        check("dec_dn_unf", 8'(if1.unf),       8'd1);
        if1.en = 1'b0;
        if1.load = 1'b1;
        if1.load_val = 4'd12;
        tick();
        check("dec_ld12",  8'(if1.bin_count), 8'd9);
        check("dec_max",   8'(if1.at_max),    8'd1);
        check("dec_unf0",  8'(if1.unf),       8'd0);
        if1.load = 1'b0;

        // Decade saturate
        if2.load = 1'b1;
        if2.load_val = 4'd8;
        tick();
        if2.load = 1'b0;
        if2.en = 1'b1;
        if2.up_down = 1'b1;
        if2.step = 2'd3;
        tick();
        check("sat_up",      8'(if2.bin_count), 8'd9);
        check("sat_up_ovf",  8'(if2.ovf),       8'd1);
        tick();
        check("sat_hold",     8'(if2.bin_count), 8'd9);
        check("sat_hold_ovf", 8'(if2.ovf),       8'd1);
        if2.en = 1'b0;
        if2.load = 1'b1;
        if2.load_val = 4'd1;
        tick();
        if2.load = 1'b0;
        if2.en = 1'b1;
        if2.up_down = 1'b0;
        if2.step = 2'd2;
        tick();
        check("sat_dn",     8'(if2.bin_count), 8'd0);
        check("sat_dn_unf", 8'(if2.unf),       8'd1);
        check("sat_dn_min", 8'(if2.at_min),    8'd1);
        if2.en = 1'b0;
        tick();
        check("sat_pulse", 8'(if2.unf), 8'd0);

        // Priority: clear > load > en
        if0.clear = 1'b1;
        if0.load = 1'b1;
        if0.load_val = 4'd5;
        if0.en = 1'b1;
        if0.up_down = 1'b1;
        if0.step = 2'd1;
        tick();
        check("pri_clear", 8'(if0.bin_count), 8'd0);
        if0.clear = 1'b0;
        tick();
        check("pri_load", 8'(if0.bin_count), 8'd5);
        if0.load = 1'b0;
        if0.en = 1'b0;
        tick();
        check("pri_en0", 8'(if0.bin_count), 8'd5);
        if0.en = 1'b1;
        if0.step = 2'd0;
        tick();
        check("step0_cnt", 8'(if0.bin_count), 8'd5);
        check("step0_ovf", 8'(if0.ovf),       8'd0);
        check("step0_unf", 8'(if0.unf),       8'd0);

        // Async reset between edges
        if0.en = 1'b0;
        if0.load = 1'b1;
        if0.load_val = 4'd6;
        if1.load = 1'b1;
        if1.load_val = 4'd9;
        tick();
        if0.load = 1'b0;
        if1.load = 1'b0;
        if1.en = 1'b1;
        if1.up_down = 1'b1;
        if1.step = 2'd1;
        tick();
        check("pre_rst_cnt", 8'(if0.bin_count), 8'd6);
        check("pre_rst_ovf", 8'(if1.ovf),       8'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_cnt", 8'(if0.bin_count), 8'd0);
        check("arst_min", 8'(if0.at_min),    8'd1);
        check("arst_ovf", 8'(if1.ovf),       8'd0);
        if0.en = 1'b1;
        if0.load = 1'b1;
        if0.load_val = 4'd5;
        if0.up_down = 1'b1;
        if0.step = 2'd1;
        tick();
        tick();
        check("rst_held", 8'(if0.bin_count), 8'd0);
        @(negedge clk);
        rst = 1'b0;
        if0.load = 1'b0;
        tick();
        check("post_rst", 8'(if0.bin_count), 8'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
